// File: rtl/neopix_pkg.sv
// Shared types and helpers for the WS2812 (NeoPixel) serializer.
// Converts nanosecond timings into whole system-clock cycles.
package neopix_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Truncating conversion; the clock is assumed to be a whole number of MHz.
    function automatic int ns_to_cyc(input int clock, input int ns);
        return (clock / 1000000) * ns / 1000;
    endfunction

endpackage

// File: rtl/neopix_encoder.sv
// Serializes bytes MSB first into the single-wire WS2812 NRZ waveform,
// followed by a low latch gap and a one-cycle frame_done_o pulse.
module neopix_encoder
    import neopix_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int BIT_NS       = 1250,
    parameter int LATCH_US     = 60
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              dout_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              underrun_o
);

    localparam int T0H_CYC   = ns_to_cyc(SYSTEM_CLOCK, T0H_NS);
    localparam int T1H_CYC   = ns_to_cyc(SYSTEM_CLOCK, T1H_NS);
    localparam int BIT_CYC   = ns_to_cyc(SYSTEM_CLOCK, BIT_NS);
    localparam int LATCH_CYC = ns_to_cyc(SYSTEM_CLOCK, LATCH_US * 1000);
    localparam int TIMER_W   = $clog2(LATCH_CYC + 1);
    localparam int IDX_W     = $clog2(BYTE_W);

    // Timer reload values are "cycles minus one": a phase ends when the timer reads zero.
    localparam logic [TIMER_W-1:0] T0H_LD   = TIMER_W'(T0H_CYC - 1);
    localparam logic [TIMER_W-1:0] T1H_LD   = TIMER_W'(T1H_CYC - 1);
    localparam logic [TIMER_W-1:0] LOW0_LD  = TIMER_W'(BIT_CYC - T0H_CYC - 1);
    localparam logic [TIMER_W-1:0] LOW1_LD  = TIMER_W'(BIT_CYC - T1H_CYC - 1);
    localparam logic [TIMER_W-1:0] LATCH_LD = TIMER_W'(LATCH_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_TOP  = IDX_W'(BYTE_W - 1);

    if (SYSTEM_CLOCK % 1000000 != 0 || T0H_CYC == 0 || T0H_CYC >= T1H_CYC ||
        T1H_CYC >= BIT_CYC || BIT_CYC > LATCH_CYC + 1) begin : g_param_check
        $error("neopix_encoder: inconsistent timing parameters");
    end

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                last_q, last_d;
    logic                dout_q, dout_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                load;
    logic                phase_end;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        ready_o      = 1'b0;
        load         = 1'b0;
        phase_end    = (timer_q == '0);

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                load    = valid_i;
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = LOW;
                    timer_d = shift_q[BYTE_W-1] ? LOW1_LD : LOW0_LD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            LOW: begin
                if (!phase_end) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (idx_q != '0) begin
                    state_d = HIGH;
                    shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                    idx_d   = idx_q - IDX_W'(1);
                    timer_d = shift_q[BYTE_W-2] ? T1H_LD : T0H_LD;
                end else if (last_q) begin
                    state_d = LATCH;
                    timer_d = LATCH_LD;
                end else begin
                    // Zero-gap handoff: a waiting byte starts its first high phase immediately.
                    ready_o = 1'b1;
                    load    = valid_i;
                    if (!valid_i) begin
                        state_d    = LATCH;
                        timer_d    = LATCH_LD;
                        underrun_d = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = HIGH;
            shift_d = data_i;
            last_d  = last_i;
            idx_d   = IDX_TOP;
            timer_d = data_i[BYTE_W-1] ? T1H_LD : T0H_LD;
        end

        dout_d = (state_d == HIGH);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign dout_o       = dout_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_neopix_encoder.sv
// Directed bench for neopix_encoder: default 50 MHz instance plus a
// 100 MHz override instance, all expectations hand-derived from the timing table.
module tb_neopix_encoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, last_a, last_b;
    logic       ready_a, dout_a, busy_a, done_a, under_a;
    logic       ready_b, dout_b, busy_b, done_b, under_b;
    bit         sel_b = 1'b0;
    int         pass_cnt = 0;
    int         check_cnt = 0;

    always #5 clk = ~clk;

    neopix_encoder dut_a (
        .clk_i(clk), .reset_ni(reset_n), .data_i(data_a), .valid_i(valid_a),
        .last_i(last_a), .ready_o(ready_a), .dout_o(dout_a), .busy_o(busy_a),
        .frame_done_o(done_a), .underrun_o(under_a)
    );

    neopix_encoder #(.SYSTEM_CLOCK(100000000)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .data_i(data_b), .valid_i(valid_b),
        .last_i(last_b), .ready_o(ready_b), .dout_o(dout_b), .busy_o(busy_b),
        .frame_done_o(done_b), .underrun_o(under_b)
    );

    function automatic logic s_dout();  return sel_b ? dout_b  : dout_a;  endfunction
    function automatic logic s_ready(); return sel_b ? ready_b : ready_a; endfunction
    function automatic logic s_busy();  return sel_b ? busy_b  : busy_a;  endfunction
    function automatic logic s_done();  return sel_b ? done_b  : done_a;  endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic applyStimulus(input bit on_b, input logic [7:0] d, input logic v, input logic l);
        if (on_b) begin
            data_b = d; valid_b = v; last_b = l;
        end else begin
            data_a = d; valid_a = v; last_a = l;
        end
    endtask

    // Entered on the first high cycle of a last_i=1 byte; measures every bit and the latch gap.
    task automatic measureFrame(input string tag, input logic [7:0] value,
                                input int t0, input int t1, input int bitc, input int latch);
        int h;
        int l;
        for (int b = 7; b >= 0; b--) begin
            h = 0;
            while (s_dout() && h < 10000) begin h++; tick(); end
            checkOutput($sformatf("%s high bit%0d", tag, b), h, value[b] ? t1 : t0);
            l = 0;
            while (!s_dout() && !s_done() && l < 10000) begin l++; tick(); end
            if (b != 0)
                checkOutput($sformatf("%s period bit%0d", tag, b), h + l, bitc);
            else
                checkOutput($sformatf("%s tail+latch", tag), l, bitc - h + latch);
        end
        checkOutput({tag, " frame_done"}, s_done(), 1);
        checkOutput({tag, " busy at idle"}, s_busy(), 0);
        checkOutput({tag, " ready at idle"}, s_ready(), 1);
        tick();
        checkOutput({tag, " frame_done width"}, s_done(), 0);
    endtask

    initial begin
        int c, c2, nrdy, r1, r2, highs, rises, cnt_done, cnt_under, cnt_high;
        logic d, prev, r;

        reset_n = 1'b0;
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dout", dout_a, 0);
        checkOutput("reset busy", busy_a, 0);
        checkOutput("reset frame_done", done_a, 0);
        checkOutput("reset underrun", under_a, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("post-reset ready", ready_a, 1);

        $display("[TB] single byte 0xA5 with last");
        applyStimulus(0, 8'hA5, 1, 1);
        tick();
        checkOutput("a5 latency dout", dout_a, 1);
        checkOutput("a5 busy rises", busy_a, 1);
        applyStimulus(0, 8'h00, 0, 0);
        measureFrame("a5", 8'hA5, 20, 40, 62, 3000);

        $display("[TB] back-to-back 0xFF 0x00 0x81");
        applyStimulus(0, 8'hFF, 1, 0);
        tick();
        applyStimulus(0, 8'h00, 1, 0);
        nrdy = 0; highs = 0; rises = 0; prev = 1'b0; r1 = -1; r2 = -1;
        for (int k = 0; k < 1488; k++) begin
            d = dout_a;
            if (d) highs++;
            if (d && !prev) rises++;
            prev = d;
            r = ready_a;
            if (r) begin
                nrdy++;
                if (nrdy == 1) r1 = k;
                else if (nrdy == 2) r2 = k;
            end
            tick();
            if (r && nrdy == 1) applyStimulus(0, 8'h81, 1, 1);
            else if (r && nrdy == 2) applyStimulus(0, 8'h00, 0, 0);
        end
        checkOutput("b2b first ready cycle", r1, 495);
        checkOutput("b2b second ready cycle", r2, 991);
        checkOutput("b2b ready count", nrdy, 2);
        checkOutput("b2b high cycles", highs, 680);
        checkOutput("b2b rising edges", rises, 24);
        checkOutput("b2b dout after 1488", dout_a, 0);
        checkOutput("b2b busy in latch", busy_a, 1);
        c = 0;
        while (!done_a && c < 4000) begin c++; tick(); end
        checkOutput("b2b latch length", c, 3000);
        tick();

        $display("[TB] underrun on 0x01 without last");
        applyStimulus(0, 8'h01, 1, 0);
        tick();
        applyStimulus(0, 8'h00, 0, 0);
        c = 0;
        while (!under_a && c < 2000) begin c++; tick(); end
        checkOutput("underrun cycle", c, 496);
        checkOutput("underrun dout low", dout_a, 0);
        checkOutput("underrun busy", busy_a, 1);
        checkOutput("underrun ready in latch", ready_a, 0);
        tick();
        checkOutput("underrun width", under_a, 0);
        c2 = 1;
        while (!done_a && c2 < 5000) begin c2++; tick(); end
        checkOutput("underrun latch length", c2, 3000);
        tick();

        $display("[TB] valid held through latch");
        applyStimulus(0, 8'h00, 1, 1);
        tick();
        applyStimulus(0, 8'h3C, 1, 1);
        c = 0; nrdy = 0;
        while (!done_a && c < 5000) begin
            if (ready_a) nrdy++;
            c++;
            tick();
        end
        checkOutput("hold frame length", c, 3496);
        checkOutput("hold ready during frame", nrdy, 0);
        checkOutput("hold ready at idle", ready_a, 1);
        tick();
        checkOutput("hold accepted first idle", dout_a, 1);
        applyStimulus(0, 8'h00, 0, 0);
        measureFrame("3c", 8'h3C, 20, 40, 62, 3000);

        $display("[TB] reset mid high phase");
        applyStimulus(0, 8'h80, 1, 1);
        tick();
        applyStimulus(0, 8'h00, 0, 0);
        repeat (30) tick();
        checkOutput("pre-abort dout", dout_a, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort dout async", dout_a, 0);
        checkOutput("abort busy", busy_a, 0);
        #20;
        reset_n = 1'b1;
        tick();
        checkOutput("abort ready", ready_a, 1);
        checkOutput("abort idle busy", busy_a, 0);
        cnt_done = 0; cnt_under = 0; cnt_high = 0;
        repeat (4000) begin
            if (done_a) cnt_done++;
            if (under_a) cnt_under++;
            if (dout_a) cnt_high++;
            tick();
        end
        checkOutput("abort no frame_done", cnt_done, 0);
        checkOutput("abort no underrun", cnt_under, 0);
        checkOutput("abort line quiet", cnt_high, 0);

        $display("[TB] 100 MHz instance, 0x80");
        sel_b = 1'b1;
        applyStimulus(1, 8'h80, 1, 1);
        tick();
        checkOutput("clk100 latency dout", dout_b, 1);
        applyStimulus(1, 8'h00, 0, 0);
        measureFrame("clk100", 8'h80, 40, 80, 125, 6000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
